l2_req_responder: RTL and testbench

// Responder end of the L2 request channel: accepts L2 req_out messages and returns rsp_in messages from a

---
 rtl/l2_req_responder.sv | 184 ++++++++++++++++++
 tb/tb_l2_req_responder.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_req_responder.sv
// Responder end of the L2 request channel: serves one request at a time from a small
// line-granular backing store and returns the response after a programmable latency.
module l2_req_responder #(
  parameter int ADDR_W     = 28,
  parameter int WORDS      = 4,
  parameter int WORD_W     = 32,
  parameter int DEPTH_LOG2 = 6,
  parameter int LATENCY    = 2,
  parameter int REQ_W      = 3,
  parameter int RSP_W      = 3,
  parameter int LINE_W     = WORDS * WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [REQ_W-1:0]  req_coh_msg,
  input  logic              req_hprot,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LINE_W-1:0] req_line,
  input  logic [WORDS-1:0]  req_word_mask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RSP_W-1:0]  rsp_coh_msg,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [LINE_W-1:0] rsp_line,
  output logic [WORDS-1:0]  rsp_word_mask,
  output logic              init_done
);

  localparam logic [REQ_W-1:0] REQ_V     = REQ_W'(0);
  localparam logic [REQ_W-1:0] REQ_S     = REQ_W'(1);
  localparam logic [REQ_W-1:0] REQ_O     = REQ_W'(2);
  localparam logic [REQ_W-1:0] REQ_ODATA = REQ_W'(3);
  localparam logic [REQ_W-1:0] REQ_WT    = REQ_W'(4);
  localparam logic [REQ_W-1:0] REQ_WB    = REQ_W'(5);

  localparam logic [RSP_W-1:0] RSP_V      = RSP_W'(0);
  localparam logic [RSP_W-1:0] RSP_S      = RSP_W'(1);
  localparam logic [RSP_W-1:0] RSP_O      = RSP_W'(2);
  localparam logic [RSP_W-1:0] RSP_ODATA  = RSP_W'(3);
  localparam logic [RSP_W-1:0] RSP_WTACK  = RSP_W'(4);
  localparam logic [RSP_W-1:0] RSP_WB_ACK = RSP_W'(5);
  localparam logic [RSP_W-1:0] RSP_NACK   = RSP_W'(6);

  localparam logic [2:0] ST_INIT   = 3'd0;
  localparam logic [2:0] ST_IDLE   = 3'd1;
  localparam logic [2:0] ST_ACCESS = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_RSP    = 3'd4;

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [2:0]            state;
  logic [DEPTH_LOG2-1:0] init_ptr;
  logic [3:0]            lat_cnt;

  logic [REQ_W-1:0]      req_msg_p0;
  logic [ADDR_W-1:0]     req_addr_p0;
  logic [LINE_W-1:0]     req_line_p0;
  logic [WORDS-1:0]      req_mask_p0;
  logic [DEPTH_LOG2-1:0] idx_p0;

  logic [LINE_W-1:0]     mem [0:DEPTH-1];

  logic                  unused_hprot;
  assign unused_hprot = req_hprot;

  assign idx_p0 = req_addr_p0[DEPTH_LOG2-1:0];

  function automatic logic is_write(input logic [REQ_W-1:0] m);
    return (m == REQ_WT) || (m == REQ_WB);
  endfunction

  function automatic logic is_read(input logic [REQ_W-1:0] m);
    return (m == REQ_V) || (m == REQ_S) || (m == REQ_ODATA);
  endfunction

  function automatic logic [RSP_W-1:0] rsp_code(input logic [REQ_W-1:0] m);
    logic [RSP_W-1:0] c;
    case (m)
      REQ_V:     c = RSP_V;
      REQ_S:     c = RSP_S;
      REQ_O:     c = RSP_O;
      REQ_ODATA: c = RSP_ODATA;
      REQ_WT:    c = RSP_WTACK;
      REQ_WB:    c = RSP_WB_ACK;
      default:   c = RSP_NACK;
    endcase
    return c;
  endfunction

  function automatic logic [LINE_W-1:0] merge_line(input logic [LINE_W-1:0] old_line,
                                                   input logic [LINE_W-1:0] new_line,
                                                   input logic [WORDS-1:0]  mask);
    logic [LINE_W-1:0] res;
    res = old_line;
    for (int w = 0; w < WORDS; w++) begin
      if (mask[w]) res[w*WORD_W +: WORD_W] = new_line[w*WORD_W +: WORD_W];
    end
    return res;
  endfunction

  // Stage p0: request fields captured on the accept handshake
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && req_valid && req_ready) begin
      req_msg_p0  <= req_coh_msg;
      req_addr_p0 <= req_addr;
      req_line_p0 <= req_line;
      req_mask_p0 <= req_word_mask;
    end
  end

  // Backing store: cleared line by line during INIT, masked writes in ACCESS
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      mem[init_ptr] <= '0;
    end else if (state == ST_ACCESS && is_write(req_msg_p0)) begin
      mem[idx_p0] <= merge_line(mem[idx_p0], req_line_p0, req_mask_p0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_INIT;
      init_ptr      <= '0;
      lat_cnt       <= '0;
      req_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      init_done     <= 1'b0;
      rsp_coh_msg   <= '0;
      rsp_addr      <= '0;
      rsp_line      <= '0;
      rsp_word_mask <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          init_ptr <= init_ptr + 1'b1;
          if (init_ptr == '1) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
            init_done <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            state     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          rsp_coh_msg   <= rsp_code(req_msg_p0);
          rsp_addr      <= req_addr_p0;
          rsp_word_mask <= req_mask_p0;
          rsp_line      <= is_read(req_msg_p0) ? mem[idx_p0] : '0;
          lat_cnt       <= 4'(LATENCY - 1);
          // A latency of one has no WAIT cycle at all
          if (LATENCY <= 1) begin
            state     <= ST_RSP;
            rsp_valid <= 1'b1;
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          lat_cnt <= lat_cnt - 4'd1;
          if (lat_cnt <= 4'd1) begin
            state     <= ST_RSP;
            rsp_valid <= 1'b1;
          end
        end
        ST_RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_req_responder.sv
// Directed bench for l2_req_responder: a line-store model predicts every response and a
// negedge monitor compares the DUT against it; literal checks pin the model.
module tb_l2_req_responder;

  localparam int LAT = 2;

  localparam logic [2:0] REQ_V     = 3'd0;
  localparam logic [2:0] REQ_S     = 3'd1;
  localparam logic [2:0] REQ_O     = 3'd2;
  localparam logic [2:0] REQ_ODATA = 3'd3;
  localparam logic [2:0] REQ_WT    = 3'd4;
  localparam logic [2:0] REQ_WB    = 3'd5;

  localparam logic [2:0] RSP_V      = 3'd0;
  localparam logic [2:0] RSP_S      = 3'd1;
  localparam logic [2:0] RSP_O      = 3'd2;
  localparam logic [2:0] RSP_ODATA  = 3'd3;
  localparam logic [2:0] RSP_WTACK  = 3'd4;
  localparam logic [2:0] RSP_WB_ACK = 3'd5;
  localparam logic [2:0] RSP_NACK   = 3'd6;

  localparam logic [127:0] L2 = 128'h44443333_22221111_AAAA9999_88887777;
  localparam logic [127:0] L3 = 128'h44443333_22221111_DEADBEEF_88887777;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [2:0]   req_coh_msg = '0;
  logic         req_hprot = 1'b0;
  logic [27:0]  req_addr = '0;
  logic [127:0] req_line = '0;
  logic [3:0]   req_word_mask = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [2:0]   rsp_coh_msg;
  logic [27:0]  rsp_addr;
  logic [127:0] rsp_line;
  logic [3:0]   rsp_word_mask;
  logic         init_done;

  l2_req_responder #(.LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_coh_msg(req_coh_msg),
    .req_hprot(req_hprot), .req_addr(req_addr), .req_line(req_line),
    .req_word_mask(req_word_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_coh_msg(rsp_coh_msg),
    .rsp_addr(rsp_addr), .rsp_line(rsp_line), .rsp_word_mask(rsp_word_mask),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Model state
  logic [127:0] mdl_mem [64];
  bit           pending = 0;
  bit           seen = 0;
  int           n = 0;
  int           t_hs = 0;
  logic [2:0]   exp_msg;
  logic [27:0]  exp_addr;
  logic [127:0] exp_line;
  logic [3:0]   exp_mask;
  logic [2:0]   last_msg;
  logic [27:0]  last_addr;
  logic [127:0] last_line;
  logic [3:0]   last_mask;
  int           last_lat;

  task automatic model_accept(input logic [2:0] msg, input logic [27:0] addr,
                              input logic [127:0] line, input logic [3:0] mask);
    int idx;
    idx      = int'(addr) % 64;
    exp_addr = addr;
    exp_mask = mask;
    exp_line = '0;
    case (msg)
      REQ_V:     begin exp_msg = RSP_V;     exp_line = mdl_mem[idx]; end
      REQ_S:     begin exp_msg = RSP_S;     exp_line = mdl_mem[idx]; end
      REQ_ODATA: begin exp_msg = RSP_ODATA; exp_line = mdl_mem[idx]; end
      REQ_O:     exp_msg = RSP_O;
      REQ_WT, REQ_WB: begin
        exp_msg = (msg == REQ_WT) ? RSP_WTACK : RSP_WB_ACK;
        for (int w = 0; w < 4; w++)
          if (mask[w]) mdl_mem[idx][w*32 +: 32] = line[w*32 +: 32];
      end
      default:   exp_msg = RSP_NACK;
    endcase
  endtask

  // Per-cycle compare process
  initial begin
    forever begin
      @(negedge clk);
      n++;
      if (rst) begin
        pending = 0;
        for (int i = 0; i < 64; i++) mdl_mem[i] = '0;
      end else begin
        if (pending) begin
          if (!seen) begin
            if (rsp_valid) begin
              seen     = 1;
              last_lat = n - t_hs;
              chk("rsp_latency", 128'(n - t_hs), 128'(LAT + 1));
            end else if (n - t_hs > LAT + 1) begin
              chk("rsp_missing", 128'(rsp_valid), 128'd1);
              pending = 0;
            end
          end
          if (pending && rsp_valid) begin
            chk("rsp_coh_msg", 128'(rsp_coh_msg), 128'(exp_msg));
            chk("rsp_addr", 128'(rsp_addr), 128'(exp_addr));
            chk("rsp_line", rsp_line, exp_line);
            chk("rsp_word_mask", 128'(rsp_word_mask), 128'(exp_mask));
            chk("req_ready_during_rsp", 128'(req_ready), 128'd0);
            if (rsp_ready) begin
              last_msg  = rsp_coh_msg;
              last_addr = rsp_addr;
              last_line = rsp_line;
              last_mask = rsp_word_mask;
              pending   = 0;
            end
          end
        end else begin
          chk("rsp_valid_idle", 128'(rsp_valid), 128'd0);
        end
        if (req_valid && req_ready) begin
          chk("accept_while_busy", 128'(pending), 128'd0);
          model_accept(req_coh_msg, req_addr, req_line, req_word_mask);
          pending = 1;
          seen    = 0;
          t_hs    = n;
        end
      end
    end
  end

  task automatic send(input logic [2:0] msg, input logic [27:0] addr,
                      input logic [127:0] line, input logic [3:0] mask, input bit wait_rsp);
    int k;
    @(posedge clk); #1;
    req_valid     = 1'b1;
    req_coh_msg   = msg;
    req_addr      = addr;
    req_line      = line;
    req_word_mask = mask;
    req_hprot     = ~req_hprot;
    k = 0;
    while (!req_ready && k < 100) begin @(posedge clk); #1; k++; end
    if (k >= 100) chk("req_accept_timeout", 128'(req_ready), 128'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (wait_rsp) begin
      k = 0;
      while (pending && k < 200) begin @(posedge clk); #1; k++; end
      if (k >= 200) chk("rsp_timeout", 128'(pending), 128'd0);
    end
  endtask

  task automatic pulse_rst_and_init();
    int zeros;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_req_ready", 128'(req_ready), 128'd0);
    chk("rst_rsp_valid", 128'(rsp_valid), 128'd0);
    chk("rst_init_done", 128'(init_done), 128'd0);
    chk("rst_rsp_coh_msg", 128'(rsp_coh_msg), 128'd0);
    chk("rst_rsp_addr", 128'(rsp_addr), 128'd0);
    chk("rst_rsp_line", rsp_line, 128'd0);
    chk("rst_rsp_word_mask", 128'(rsp_word_mask), 128'd0);
    zeros = 0;
    while (!req_ready && zeros < 300) begin
      @(negedge clk);
      if (!req_ready) begin
        zeros++;
        if (init_done) chk("init_done_early", 128'(init_done), 128'd0);
      end
    end
    chk("init_cycles", 128'(zeros), 128'd64);
    chk("init_done_set", 128'(init_done), 128'd1);
  endtask

  task automatic expect_last(input string name, input logic [2:0] msg, input logic [27:0] addr,
                             input logic [127:0] line, input logic [3:0] mask);
    chk({name, "_msg"}, 128'(last_msg), 128'(msg));
    chk({name, "_addr"}, 128'(last_addr), 128'(addr));
    chk({name, "_line"}, last_line, line);
    chk({name, "_mask"}, 128'(last_mask), 128'(mask));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [127:0] held_line;
    logic [2:0]   held_msg;
    int k;

    // 1: reset, INIT sweep, first read of a cleared line
    @(posedge clk); #1;
    pulse_rst_and_init();
    send(REQ_V, 28'h5, '0, 4'hF, 1);
    expect_last("t1_read", RSP_V, 28'h5, 128'd0, 4'hF);

    // 2: full-line writeback then shared read
    send(REQ_WB, 28'h12, L2, 4'hF, 1);
    expect_last("t2_wb", RSP_WB_ACK, 28'h12, 128'd0, 4'hF);
    chk("t2_latency", 128'(last_lat), 128'd3);
    send(REQ_S, 28'h12, '0, 4'hF, 1);
    expect_last("t2_s", RSP_S, 28'h12, L2, 4'hF);

    // 3: single-word write-through
    send(REQ_WT, 28'h12, 128'hFFFFFFFF_FFFFFFFF_DEADBEEF_FFFFFFFF, 4'b0010, 1);
    expect_last("t3_wt", RSP_WTACK, 28'h12, 128'd0, 4'b0010);
    send(REQ_V, 28'h12, '0, 4'b0001, 1);
    expect_last("t3_v", RSP_V, 28'h12, L3, 4'b0001);

    // 4: response back-pressure
    rsp_ready = 1'b0;
    send(REQ_S, 28'h12, '0, 4'b0100, 0);
    k = 0;
    while (!rsp_valid && k < 50) begin @(posedge clk); #1; k++; end
    chk("t4_valid_seen", 128'(rsp_valid), 128'd1);
    held_line = rsp_line;
    held_msg  = rsp_coh_msg;
    chk("t4_held_line", held_line, L3);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("t4_hold_valid", 128'(rsp_valid), 128'd1);
      chk("t4_hold_req_ready", 128'(req_ready), 128'd0);
      chk("t4_hold_line", rsp_line, held_line);
      chk("t4_hold_msg", 128'(rsp_coh_msg), 128'(held_msg));
    end
    rsp_ready = 1'b1;
    k = 0;
    while (pending && k < 50) begin @(posedge clk); #1; k++; end
    chk("t4_released", 128'(pending), 128'd0);
    @(negedge clk);
    chk("t4_valid_dropped", 128'(rsp_valid), 128'd0);
    chk("t4_ready_back", 128'(req_ready), 128'd1);
    send(REQ_O, 28'h30, L2, 4'b1001, 1);
    expect_last("t4_o", RSP_O, 28'h30, 128'd0, 4'b1001);

    // 5: aliasing and an empty write mask
    send(REQ_ODATA, 28'h52, '0, 4'b1010, 1);
    expect_last("t5_alias", RSP_ODATA, 28'h52, L3, 4'b1010);
    send(REQ_WT, 28'hABCD012, '1, 4'b0000, 1);
    expect_last("t5_mask0", RSP_WTACK, 28'hABCD012, 128'd0, 4'b0000);
    send(REQ_V, 28'h12, '0, 4'hF, 1);
    expect_last("t5_after_mask0", RSP_V, 28'h12, L3, 4'hF);

    // 6: undefined opcode, then reset in the middle of WAIT
    send(3'd7, 28'h12, '1, 4'hF, 1);
    expect_last("t6_nack", RSP_NACK, 28'h12, 128'd0, 4'hF);
    send(REQ_V, 28'h12, '0, 4'hF, 1);
    expect_last("t6_unchanged", RSP_V, 28'h12, L3, 4'hF);
    send(REQ_V, 28'h12, '0, 4'hF, 0);
    @(posedge clk); #1;
    pulse_rst_and_init();
    send(REQ_V, 28'h12, '0, 4'hF, 1);
    expect_last("t6_cleared", RSP_V, 28'h12, 128'd0, 4'hF);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
